// File: rtl/write_port_arbiter.sv
// Round-robin arbiter granting one of N_MASTERS bursting writers access to a shared
// slave write port; ownership ends after BURST_LEN beats or TIMEOUT idle cycles.
module write_port_arbiter #(
  parameter int N_MASTERS = 8,
  parameter int LANES     = 6,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16,
  localparam int ID_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int BEAT_W   = LANES * DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_wvalid,
  output logic [N_MASTERS-1:0]          m_wready,
  input  logic [N_MASTERS*BEAT_W-1:0]   m_wdata,
  output logic                          s_wvalid,
  input  logic                          s_wready,
  output logic [BEAT_W-1:0]             s_wdata,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic [7:0]      idle_cnt_q, idle_cnt_d;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic            beat;
  logic            owner_valid;
  logic [BEAT_W-1:0] slice [N_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
      assign slice[gi]    = m_wdata[gi*BEAT_W +: BEAT_W];
      assign m_wready[gi] = busy & rst_n & s_wready & (grant_id_q == ID_W'(gi));
    end
  endgenerate

  assign busy        = (state_q == GRANT);
  assign grant_id    = grant_id_q;
  assign owner_valid = m_wvalid[grant_id_q];
  // Outputs are forced quiet while rst_n is low so no beat slips through the reset edge.
  assign s_wvalid    = busy & rst_n & owner_valid;
  assign s_wdata     = slice[grant_id_q];
  assign beat        = s_wvalid & s_wready;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_id    = rr_ptr_q;
    idx        = 0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (m_wvalid[idx]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    logic release_now;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      default: begin
        if (beat) begin
          idle_cnt_d = '0;
          if (beat_cnt_q == 8'(BURST_LEN - 1)) release_now = 1'b1;
          else beat_cnt_d = beat_cnt_q + 8'd1;
        end else if (!owner_valid) begin
          if (idle_cnt_q == 8'(TIMEOUT - 1)) release_now = 1'b1;
          else idle_cnt_d = idle_cnt_q + 8'd1;
        end
        // A stalled beat (valid, not ready) leaves both counters untouched.
        if (release_now) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_id_q == ID_W'(N_MASTERS - 1)) ? '0 : grant_id_q + ID_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_write_port_arbiter.sv
// Directed bench for write_port_arbiter: round-robin order, burst length, idle timeout,
// slave stall, mid-burst reset and data steering.
module tb_write_port_arbiter;

  localparam int N      = 8;
  localparam int BEAT_W = 6 * 32;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      m_wvalid;
  logic [N-1:0]      m_wready;
  logic [N*BEAT_W-1:0] m_wdata;
  logic              s_wvalid;
  logic              s_wready;
  logic [BEAT_W-1:0] s_wdata;
  logic [2:0]        grant_id;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int beats_seen [N];
  int beat_total = 0;
  int grant_log [$];
  logic prev_busy = 1'b0;

  write_port_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_wvalid (m_wvalid),
    .m_wready (m_wready),
    .m_wdata  (m_wdata),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_wdata  (s_wdata),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [BEAT_W-1:0] exp_slice(input int m);
    logic [BEAT_W-1:0] v;
    for (int l = 0; l < 6; l++) v[l*32 +: 32] = {8'hA5, 8'(m), 8'(l), 8'h3C};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  // Beat monitor: steering and one-hot ready checked on every accepted beat.
  always @(negedge clk) begin
    prev_busy <= busy;
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    if (s_wvalid && s_wready) begin
      chk("beat_data", s_wdata, exp_slice(int'(grant_id)));
      chk("beat_ready", m_wready, 8'(1) << grant_id);
      beats_seen[grant_id] <= beats_seen[grant_id] + 1;
      beat_total <= beat_total + 1;
    end
  end

  initial begin
    int snap [N];
    int base;
    int guard;
    for (int m = 0; m < N; m++) begin
      m_wdata[m*BEAT_W +: BEAT_W] = exp_slice(m);
      beats_seen[m] = 0;
    end
    rst_n = 1'b0;
    m_wvalid = '0;
    s_wready = 1'b1;

    tick(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_svalid", s_wvalid, 1'b0);
    chk("rst_wready", m_wready, 8'h00);
    chk("rst_grant", grant_id, 3'd0);
    rst_n = 1'b1;

    // Single master 3, full burst.
    m_wvalid = 8'h08;
    snap = beats_seen;
    tick(1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_grant", grant_id, 3'd3);
    guard = 0;
    while (busy && guard < 20) begin tick(1); guard++; end
    m_wvalid = '0;
    chk("t1_released", busy, 1'b0);
    chk("t1_beats", beats_seen[3] - snap[3], 4);
    chk("t1_rr_ptr", dut.rr_ptr_q, 3'd4);

    // Masters 0,2,5: order 0,2,5,0 with one arbitration cycle per grant.
    do_reset();
    m_wvalid = 8'b0010_0101;
    snap = beats_seen;
    base = grant_log.size();
    tick(20);
    m_wvalid = '0;
    chk("t2_ngrants", grant_log.size() - base, 4);
    chk("t2_g0", grant_log[base], 0);
    chk("t2_g1", grant_log[base+1], 2);
    chk("t2_g2", grant_log[base+2], 5);
    chk("t2_g3", grant_log[base+3], 0);
    chk("t2_busy_end", busy, 1'b0);
    chk("t2_b0", beats_seen[0] - snap[0], 8);
    chk("t2_b2", beats_seen[2] - snap[2], 4);
    chk("t2_b5", beats_seen[5] - snap[5], 4);

    // Master 1 stops after 2 beats: 16 idle cycles then master 6.
    do_reset();
    m_wvalid = 8'b0100_0010;
    snap = beats_seen;
    tick(1);
    chk("t3_grant1", grant_id, 3'd1);
    tick(2);
    m_wvalid = 8'b0100_0000;
    chk("t3_beats1", beats_seen[1] - snap[1], 2);
    tick(15);
    chk("t3_hold15", busy, 1'b1);
    tick(1);
    chk("t3_release16", busy, 1'b0);
    tick(1);
    chk("t3_busy6", busy, 1'b1);
    chk("t3_grant6", grant_id, 3'd6);
    tick(4);
    m_wvalid = '0;
    chk("t3_beats6", beats_seen[6] - snap[6], 4);

    // Master 4 with a 40-cycle slave stall after its first beat.
    do_reset();
    m_wvalid = 8'h10;
    snap = beats_seen;
    tick(1);
    chk("t4_grant4", grant_id, 3'd4);
    tick(1);
    s_wready = 1'b0;
    tick(40);
    chk("t4_stall_busy", busy, 1'b1);
    chk("t4_stall_cnt", dut.beat_cnt_q, 8'd1);
    chk("t4_stall_beats", beats_seen[4] - snap[4], 1);
    s_wready = 1'b1;
    tick(3);
    m_wvalid = '0;
    chk("t4_done", busy, 1'b0);
    chk("t4_beats", beats_seen[4] - snap[4], 4);

    // Reset after the 2nd beat of master 7.
    do_reset();
    m_wvalid = 8'h80;
    snap = beats_seen;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_svalid", s_wvalid, 1'b0);
    chk("t5_rr_ptr", dut.rr_ptr_q, 3'd0);
    chk("t5_beats", beats_seen[7] - snap[7], 2);
    rst_n = 1'b1;
    tick(1);
    chk("t5_regrant", grant_id, 3'd7);
    chk("t5_rebusy", busy, 1'b1);
    tick(4);
    m_wvalid = '0;
    chk("t5_reburst", beats_seen[7] - snap[7], 6);

    // All masters, 64 beats: 8 each.
    do_reset();
    m_wvalid = 8'hFF;
    snap = beats_seen;
    base = beat_total;
    guard = 0;
    while ((beat_total - base) < 64 && guard < 300) begin tick(1); guard++; end
    m_wvalid = '0;
    chk("t6_total", beat_total - base, 64);
    for (int m = 0; m < N; m++) chk($sformatf("t6_b%0d", m), beats_seen[m] - snap[m], 8);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
